// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner: halfword queue that realigns 16/32-bit RISC-V instructions.
// Ports: fetch beat in (valid/ready), one instruction out per cycle (valid/ready),
// flush redirect, hw_count_o occupancy. Define ALIGNER_EXPAND_EN to expand RVC.
module rvc_fetch_aligner #(
  parameter int FETCH_HW = 2,
  parameter int DEPTH_HW = 8,
  parameter int PC_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic [PC_W-1:0]             flush_pc_i,
  input  logic                        fetch_valid_i,
  output logic                        fetch_ready_o,
  input  logic [16*FETCH_HW-1:0]      fetch_data_i,
  input  logic [PC_W-1:0]             fetch_pc_i,
  output logic                        inst_valid_o,
  input  logic                        inst_ready_i,
  output logic [31:0]                 inst_o,
  output logic [PC_W-1:0]             inst_pc_o,
  output logic                        inst_comp_o,
  output logic                        inst_illegal_o,
  output logic [$clog2(DEPTH_HW):0]   hw_count_o
);

  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(FETCH_HW);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [15:0]   hw_q [DEPTH_HW];
  logic [PC_W-1:0] pc_q [DEPTH_HW];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] skip_q, skip_d;

  logic [15:0] h0, h1;
  logic        is32, push, pop;
  logic [CW-1:0] pushed, popped;
  logic        unused_pc;

  assign unused_pc = ^{flush_pc_i[PC_W-1:SW+1], flush_pc_i[0]};

  assign h0   = hw_q[rd_ptr_q];
  assign h1   = hw_q[rd_ptr_q + PW'(1)];
  assign is32 = (h0[1:0] == 2'b11);

  assign fetch_ready_o = rst_n & (count_q <= CW'(DEPTH_HW - FETCH_HW));
  assign inst_valid_o  = rst_n & ~flush_i &
                         (is32 ? (count_q >= CW'(2)) : (count_q != '0));
  assign hw_count_o    = count_q;

  assign push   = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop    = inst_valid_o & inst_ready_i;
  assign pushed = CW'(FETCH_HW) - CW'(skip_q);
  assign popped = is32 ? CW'(2) : CW'(1);

`ifdef ALIGNER_EXPAND_EN
  // Returns {illegal, inst}; illegal encodings yield the NOP pattern.
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] i;
    logic        ill;
    logic [4:0]  rd, rs2, rdp, rsp;
    logic [11:0] jo;
    logic [8:0]  bo;
    logic [2:0]  f3;
    rd  = c[11:7];
    rs2 = c[6:2];
    rdp = {2'b01, c[4:2]};
    rsp = {2'b01, c[9:7]};
    jo  = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    bo  = {c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
    i   = NOP;
    ill = 1'b0;
    f3  = 3'b000;
    unique case ({c[15:13], c[1:0]})
      5'b000_00: begin
        if (c[12:5] == '0) ill = 1'b1;
        else i = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00,
                  5'd2, 3'b000, rdp, 7'h13};
      end
      5'b010_00: i = {5'b0, c[5], c[12:10], c[6], 2'b00,
                      rsp, 3'b010, rdp, 7'h03};
      5'b110_00: i = {5'b0, c[5], c[12], rdp, rsp, 3'b010,
                      c[11:10], c[6], 2'b00, 7'h23};
      5'b000_01: i = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
      5'b001_01: i = {jo[11], jo[10:1], jo[11], {8{jo[11]}},
                      5'd1, 7'h6f};
      5'b010_01: i = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
      5'b011_01: begin
        if ({c[12], c[6:2]} == '0) ill = 1'b1;
        else if (rd == 5'd2)
          i = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0,
               5'd2, 3'b000, 5'd2, 7'h13};
        else
          i = {{15{c[12]}}, c[6:2], rd, 7'h37};
      end
      5'b100_01: begin
        unique case (c[11:10])
          2'b00: if (c[12]) ill = 1'b1;
                 else i = {7'h00, c[6:2], rsp, 3'b101, rsp, 7'h13};
          2'b01: if (c[12]) ill = 1'b1;
                 else i = {7'h20, c[6:2], rsp, 3'b101, rsp, 7'h13};
          2'b10: i = {{7{c[12]}}, c[6:2], rsp, 3'b111, rsp, 7'h13};
          default: begin
            unique case (c[6:5])
              2'b00:   f3 = 3'b000;
              2'b01:   f3 = 3'b100;
              2'b10:   f3 = 3'b110;
              default: f3 = 3'b111;
            endcase
            if (c[12]) ill = 1'b1;
            else i = {(c[6:5] == 2'b00) ? 7'h20 : 7'h00,
                      rdp, rsp, f3, rsp, 7'h33};
          end
        endcase
      end
      5'b101_01: i = {jo[11], jo[10:1], jo[11], {8{jo[11]}},
                      5'd0, 7'h6f};
      5'b110_01, 5'b111_01:
        i = {bo[8], {3{bo[8]}}, bo[7:5], 5'd0, rsp,
             {2'b00, c[13]}, bo[4:1], bo[8], 7'h63};
      5'b000_10: begin
        if (c[12]) ill = 1'b1;
        else i = {7'h00, c[6:2], rd, 3'b001, rd, 7'h13};
      end
      5'b010_10: begin
        if (rd == '0) ill = 1'b1;
        else i = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
                  5'd2, 3'b010, rd, 7'h03};
      end
      5'b100_10: begin
        if (!c[12]) begin
          if (rs2 != '0) i = {7'h00, rs2, 5'd0, 3'b000, rd, 7'h33};
          else if (rd == '0) ill = 1'b1;
          else i = {12'h0, rd, 3'b000, 5'd0, 7'h67};
        end else begin
          if (rs2 != '0) i = {7'h00, rs2, rd, 3'b000, rd, 7'h33};
          else if (rd == '0) i = 32'h0010_0073;
          else i = {12'h0, rd, 3'b000, 5'd1, 7'h67};
        end
      end
      5'b110_10: i = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
                      c[11:9], 2'b00, 7'h23};
      default: ill = 1'b1;
    endcase
    return {ill, i};
  endfunction
`endif

  always_comb begin
    inst_o         = NOP;
    inst_pc_o      = '0;
    inst_comp_o    = 1'b0;
    inst_illegal_o = 1'b0;
    if (rst_n) begin
      inst_pc_o = pc_q[rd_ptr_q];
      if (is32) begin
        inst_o = {h1, h0};
      end else begin
        inst_comp_o = 1'b1;
`ifdef ALIGNER_EXPAND_EN
        {inst_illegal_o, inst_o} = expand(h0);
        if (h0 == '0) begin
          inst_o         = '0;
          inst_illegal_o = 1'b1;
        end
`else
        inst_o         = {16'h0, h0};
        inst_illegal_o = (h0 == '0);
`endif
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    skip_d   = skip_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      skip_d   = flush_pc_i[SW:1];
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(FETCH_HW) - PW'(skip_q);
        skip_d   = '0;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(popped);
      count_d = count_q + (push ? pushed : '0) - (pop ? popped : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      skip_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      skip_q   <= skip_d;
    end
  end

  // Halfwords below the entry offset of a redirect are not written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_HW; k++) begin
      if (push && k >= int'(skip_q)) begin
        hw_q[wr_ptr_q + PW'(k) - PW'(skip_q)] <= fetch_data_i[16*k +: 16];
        pc_q[wr_ptr_q + PW'(k) - PW'(skip_q)] <= fetch_pc_i + PC_W'(2*k);
      end
    end
  end

endmodule
